// File: rtl/branch_unit.sv
// Multi-cycle RV64 conditional-branch resolver: accepts a decoded branch, drives the external
// comparator for one cycle, then holds taken/redirect-PC until the consumer takes it.
module branch_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [2:0]      in_funct3,
  output logic [XLEN-1:0] cmp_src1,
  output logic [XLEN-1:0] cmp_src2,
  output logic [3:0]      cmp_ctrl,
  input  logic [XLEN-1:0] cmp_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_misalign,
  output logic            out_illegal,
  input  logic            flush
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  localparam logic [3:0] CmpNeq  = 4'd0;
  localparam logic [3:0] CmpEq   = 4'd1;
  localparam logic [3:0] CmpGe   = 4'd2;
  localparam logic [3:0] CmpLt   = 4'd3;
  localparam logic [3:0] CmpLtu  = 4'd4;
  localparam logic [3:0] CmpIdle = 4'd15;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, src1_q, src1_d, src2_q, src2_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            inv_q, inv_d, ill_q, ill_d;
  logic            taken_q, taken_d, mis_q, mis_d, illo_q, illo_d;
  logic [XLEN-1:0] npc_q, npc_d;

  logic [3:0]      sel_ctrl;
  logic            sel_inv, sel_ill;
  logic            eval_taken;
  logic [XLEN-1:0] target, seq_pc;

  // bgeu reuses the unsigned less-than compare with the result inverted.
  always_comb begin
    sel_ctrl = CmpIdle;
    sel_inv  = 1'b0;
    sel_ill  = 1'b0;
    case (in_funct3)
      3'b000:  sel_ctrl = CmpEq;
      3'b001:  sel_ctrl = CmpNeq;
      3'b100:  sel_ctrl = CmpLt;
      3'b101:  sel_ctrl = CmpGe;
      3'b110:  sel_ctrl = CmpLtu;
      3'b111: begin
        sel_ctrl = CmpLtu;
        sel_inv  = 1'b1;
      end
      default: sel_ill = 1'b1;
    endcase
  end

  assign target     = pc_q + imm_q;
  assign seq_pc     = pc_q + XLEN'(4);
  assign eval_taken = ~ill_q & (cmp_result[0] ^ inv_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    ctrl_d  = ctrl_q;
    inv_d   = inv_q;
    ill_d   = ill_q;
    taken_d = taken_q;
    npc_d   = npc_q;
    mis_d   = mis_q;
    illo_d  = illo_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            pc_d    = in_pc;
            imm_d   = in_imm;
            src1_d  = in_src1;
            src2_d  = in_src2;
            ctrl_d  = sel_ctrl;
            inv_d   = sel_inv;
            ill_d   = sel_ill;
            state_d = StEval;
          end
        end
        StEval: begin
          taken_d = eval_taken;
          npc_d   = eval_taken ? target : seq_pc;
          mis_d   = eval_taken & (target[1:0] != 2'b00);
          illo_d  = ill_q;
          state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      imm_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      ctrl_q  <= CmpIdle;
      inv_q   <= 1'b0;
      ill_q   <= 1'b0;
      taken_q <= 1'b0;
      npc_q   <= '0;
      mis_q   <= 1'b0;
      illo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      ctrl_q  <= ctrl_d;
      inv_q   <= inv_d;
      ill_q   <= ill_d;
      taken_q <= taken_d;
      npc_q   <= npc_d;
      mis_q   <= mis_d;
      illo_q  <= illo_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign cmp_src1     = src1_q;
  assign cmp_src2     = src2_q;
  assign cmp_ctrl     = (state_q == StEval) ? ctrl_q : CmpIdle;
  assign out_taken    = taken_q;
  assign out_next_pc  = npc_q;
  assign out_misalign = mis_q;
  assign out_illegal  = illo_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed branch cases, randomized branches against a
// funct3-semantics reference model, back-pressure, throughput, flush and mid-operation reset.
module tb_branch_unit;

  localparam int unsigned XLEN = 64;

  logic            clk, rst_n;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm, in_src1, in_src2;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] cmp_src1, cmp_src2, cmp_result;
  logic [3:0]      cmp_ctrl;
  logic            out_valid, out_ready, out_taken, out_misalign, out_illegal, flush;
  logic [XLEN-1:0] out_next_pc;

  int n_checks = 0;
  int n_fail   = 0;

  branch_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_src1(in_src1), .in_src2(in_src2), .in_funct3(in_funct3),
    .cmp_src1(cmp_src1), .cmp_src2(cmp_src2), .cmp_ctrl(cmp_ctrl), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_misalign(out_misalign), .out_illegal(out_illegal),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1);
  end

  // External comparator: evaluates whatever code the unit selects.
  always_comb begin
    logic r;
    case (cmp_ctrl)
      4'd0:    r = (cmp_src1 != cmp_src2);
      4'd1:    r = (cmp_src1 == cmp_src2);
      4'd2:    r = ($signed(cmp_src1) >= $signed(cmp_src2));
      4'd3:    r = ($signed(cmp_src1) < $signed(cmp_src2));
      4'd4:    r = (cmp_src1 < cmp_src2);
      default: r = 1'b0;
    endcase
    cmp_result = {XLEN{r}};
  end

  // Reference model straight from the RISC-V branch definitions.
  function automatic void model(input logic [63:0] pc, imm, a, b, input logic [2:0] f3,
                                output logic tk, output logic [63:0] npc,
                                output logic mis, output logic ill, output logic [3:0] code);
    logic [63:0] t;
    ill = 1'b0;
    case (f3)
      3'd0:    begin tk = (a == b);                  code = 4'd1; end
      3'd1:    begin tk = (a != b);                  code = 4'd0; end
      3'd4:    begin tk = ($signed(a) < $signed(b));  code = 4'd3; end
      3'd5:    begin tk = ($signed(a) >= $signed(b)); code = 4'd2; end
      3'd6:    begin tk = (a < b);                   code = 4'd4; end
      3'd7:    begin tk = (a >= b);                  code = 4'd4; end
      default: begin tk = 1'b0; ill = 1'b1;          code = 4'd15; end
    endcase
    t   = pc + imm;
    npc = tk ? t : pc + 64'd4;
    mis = tk && ((t % 64'd4) != 64'd0);
  endfunction

  // One full transaction; returns what was observed, and ok=0 on any handshake/stability slip.
  task automatic do_branch(input logic [63:0] pc, imm, a, b, input logic [2:0] f3,
                           input int hold, output logic [3:0] code, output logic ok,
                           output logic tk, output logic [63:0] npc,
                           output logic mis, output logic ill);
    ok = 1'b1;
    @(negedge clk);
    if (in_ready !== 1'b1 || out_valid !== 1'b0) ok = 1'b0;
    in_valid = 1'b1; in_pc = pc; in_imm = imm; in_src1 = a; in_src2 = b; in_funct3 = f3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_pc = {$urandom, $urandom}; in_src1 = {$urandom, $urandom}; in_funct3 = 3'($urandom);
    @(negedge clk);
    code = cmp_ctrl;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || cmp_src1 !== a || cmp_src2 !== b) ok = 1'b0;
    @(negedge clk);
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cmp_ctrl !== 4'd15) ok = 1'b0;
    tk = out_taken; npc = out_next_pc; mis = out_misalign; ill = out_illegal;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_taken !== tk ||
          out_next_pc !== npc || out_misalign !== mis || out_illegal !== ill) ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_taken !== 1'b0 ||
        out_misalign !== 1'b0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rdy=%b vld=%b tk=%b mis=%b ill=%b, required 1 0 0 0 0",
               in_ready, out_valid, out_taken, out_misalign, out_illegal);
    end
    n_checks++;
    if (out_next_pc !== 64'd0 || cmp_src1 !== 64'd0 || cmp_src2 !== 64'd0 ||
        cmp_ctrl !== 4'd15) begin
      n_fail++;
      $display("FAIL reset_values: npc=%h s1=%h s2=%h ctrl=%0d, required 0 0 0 15",
               out_next_pc, cmp_src1, cmp_src2, cmp_ctrl);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [63:0] pc, imm, a, b;
    logic [2:0]  f3;
    logic [3:0]  code;
    logic        tk;
    logic [63:0] npc;
    logic        mis, ill;
  } vec_t;

  task automatic test_directed;
    vec_t v[10];
    logic [3:0] code; logic ok, tk, mis, ill; logic [63:0] npc;
    v[0] = '{64'h8000_0000, 64'h10, 64'h5, 64'h5, 3'd0, 4'd1, 1'b1, 64'h8000_0010, 1'b0, 1'b0};
    v[1] = '{64'h1000, 64'h40, '1, 64'h1, 3'd4, 4'd3, 1'b1, 64'h1040, 1'b0, 1'b0};
    v[2] = '{64'h1000, 64'h40, '1, 64'h1, 3'd6, 4'd4, 1'b0, 64'h1004, 1'b0, 1'b0};
    v[3] = '{64'h2000, -64'sd8, 64'h7, 64'h7, 3'd7, 4'd4, 1'b1, 64'h1FF8, 1'b0, 1'b0};
    v[4] = '{64'h3000, 64'h100, 64'h1, '1, 3'd5, 4'd2, 1'b1, 64'h3100, 1'b0, 1'b0};
    v[5] = '{64'h4000, 64'h20, 64'h9, 64'h9, 3'd2, 4'd15, 1'b0, 64'h4004, 1'b0, 1'b1};
    v[6] = '{64'h4100, 64'h20, 64'h1, 64'h2, 3'd3, 4'd15, 1'b0, 64'h4104, 1'b0, 1'b1};
    v[7] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h3, 64'h3, 3'd0, 4'd1, 1'b1, 64'h10,
             1'b0, 1'b0};
    v[8] = '{64'h5000, 64'h2, 64'hA, 64'hA, 3'd0, 4'd1, 1'b1, 64'h5002, 1'b1, 1'b0};
    v[9] = '{64'h6000, 64'h6, 64'hA, 64'hA, 3'd1, 4'd0, 1'b0, 64'h6004, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do_branch(v[i].pc, v[i].imm, v[i].a, v[i].b, v[i].f3, 0, code, ok, tk, npc, mis, ill);
      n_checks++;
      if (code !== v[i].code || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_%0d_ctrl: ctrl=%0d seq_ok=%b, required ctrl=%0d seq_ok=1",
                 i, code, ok, v[i].code);
      end
      n_checks++;
      if (tk !== v[i].tk || npc !== v[i].npc || mis !== v[i].mis || ill !== v[i].ill) begin
        n_fail++;
        $display("FAIL directed_%0d_result: tk=%b npc=%h mis=%b ill=%b, required %b %h %b %b",
                 i, tk, npc, mis, ill, v[i].tk, v[i].npc, v[i].mis, v[i].ill);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] pc, imm, a, b, enpc, npc;
    logic [12:0] r13;
    logic [2:0]  f3;
    logic [3:0]  code, ecode;
    logic        ok, tk, mis, ill, etk, emis, eill;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      pc  = {$urandom, $urandom} & ~64'h1;
      r13 = 13'($urandom);
      imm = {{51{r13[12]}}, r13};
      a   = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a + 64'($urandom_range(0, 2)) - 64'd1;
        2:       b = {$urandom, $urandom};
        default: begin
          a = 64'($signed(8'($urandom)));
          b = 64'($signed(8'($urandom)));
        end
      endcase
      model(pc, imm, a, b, f3, etk, enpc, emis, eill, ecode);
      do_branch(pc, imm, a, b, f3, $urandom_range(0, 2), code, ok, tk, npc, mis, ill);
      n_checks++;
      if (code !== ecode || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL random_%0d_ctrl: f3=%0d ctrl=%0d seq_ok=%b, required ctrl=%0d seq_ok=1",
                 i, f3, code, ok, ecode);
      end
      n_checks++;
      if (tk !== etk || npc !== enpc || mis !== emis || ill !== eill) begin
        n_fail++;
        $display("FAIL random_%0d_result: f3=%0d a=%h b=%h tk=%b npc=%h mis=%b ill=%b, %s %b %h %b %b",
                 i, f3, a, b, tk, npc, mis, ill, "required", etk, enpc, emis, eill);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] code; logic ok, tk, mis, ill; logic [63:0] npc;
    do_branch(64'h7000, 64'h44, 64'h3, 64'h9, 3'd4, 5, code, ok, tk, npc, mis, ill);
    n_checks++;
    if (ok !== 1'b1 || tk !== 1'b1 || npc !== 64'h7044) begin
      n_fail++;
      $display("FAIL backpressure_hold: seq_ok=%b tk=%b npc=%h, required 1 1 7044", ok, tk, npc);
    end
    // Next request must be accepted in the cycle right after release.
    do_branch(64'h7100, 64'h8, 64'h3, 64'h9, 3'd6, 0, code, ok, tk, npc, mis, ill);
    n_checks++;
    if (ok !== 1'b1 || tk !== 1'b1 || npc !== 64'h7108 || code !== 4'd4) begin
      n_fail++;
      $display("FAIL backpressure_next: seq_ok=%b tk=%b npc=%h ctrl=%0d, required 1 1 7108 4",
               ok, tk, npc, code);
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0, done = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 64'h9000; in_imm = 64'h10; in_src1 = 64'h1; in_src2 = 64'h1; in_funct3 = 3'd0;
    for (int c = 0; c < 9; c++) begin
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) done++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (acc != 3 || done != 3) begin
      n_fail++;
      $display("FAIL back_to_back: accepts=%0d completions=%0d in 9 cycles, required 3 and 3",
               acc, done);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    in_valid = 1'b1; in_pc = 64'hA000; in_imm = 64'h8; in_src1 = 64'h2; in_src2 = 64'h2;
    in_funct3 = 3'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    n_checks++;
    if (cmp_ctrl !== 4'd1) begin
      n_fail++;
      $display("FAIL flush_eval_ctrl: ctrl=%0d, required 1", cmp_ctrl);
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cmp_ctrl !== 4'd15) begin
      n_fail++;
      $display("FAIL flush_eval: vld=%b rdy=%b ctrl=%0d, required 0 1 15",
               out_valid, in_ready, cmp_ctrl);
    end
    // Flush together with a request in IDLE: nothing accepted.
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || cmp_ctrl !== 4'd15 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: rdy=%b ctrl=%0d vld=%b, required 1 15 0",
               in_ready, cmp_ctrl, out_valid);
    end
    // Flush while holding a result in DONE.
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1; in_pc = 64'hB000; in_imm = 64'h4; in_src1 = 64'h5; in_src2 = 64'h6;
    in_funct3 = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: vld=%b tk=%b, required 1 1", out_valid, out_taken);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || cmp_ctrl !== 4'd15 || in_ready !== 1'b1 || out_taken !== 1'b0 ||
        out_next_pc !== 64'd0 || cmp_src1 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: vld=%b ctrl=%0d rdy=%b tk=%b npc=%h s1=%h, required 0 15 1 0 0 0",
               out_valid, cmp_ctrl, in_ready, out_taken, out_next_pc, cmp_src1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: vld=%b, required 0", out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_imm = '0; in_src1 = '0; in_src2 = '0; in_funct3 = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
